// File: rtl/mux8_arb_pkg.sv
// Shared constants and helpers for the 8-channel mux/demux family.
// Channel indices use the same 3-bit select encoding as demux8.
package mux8_arb_pkg;

    localparam int NCH       = 8;
    localparam int SEL_W     = 3;
    localparam int DEF_WIDTH = 16;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [NCH-1:0]   chmask_t;

    // Round-robin pointer moves to the channel after the one just served.
    // The 3-bit add wraps 7 -> 0.
    function automatic sel_t next_ptr(input sel_t g);
        return g + sel_t'(1);
    endfunction

endpackage

// File: rtl/mux8_arb_rr_arb8.sv
// Combinational round-robin grant: first requester at or above ptr,
// wrapping past channel 7 back to channel 0.
module rr_arb8
    import mux8_arb_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] ptr,
    output logic [NCH-1:0]   grant,
    output logic [SEL_W-1:0] gidx,
    output logic             any
);

    logic [SEL_W-1:0] cand;

    // Walk the offsets from farthest to nearest, so the nearest hit wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                gidx = cand;
                any  = 1'b1;
            end
        end
        if (any) begin
            grant[gidx] = 1'b1;
        end
    end

endmodule

// File: rtl/mux8_arb.sv
// Eight valid/ready channels merged round-robin into one registered
// output stream; each word carries the index of its source channel.
module mux8_arb
    import mux8_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         in_valid,
    input  logic [NCH*WIDTH-1:0]   in_data,
    output logic [NCH-1:0]         in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [SEL_W-1:0]       out_sel,
    input  logic                   out_ready
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state_reg;
    logic [SEL_W-1:0] ptr_reg;
    logic [WIDTH-1:0] data_reg;
    logic [SEL_W-1:0] sel_reg;

    logic [WIDTH-1:0] words [NCH];
    logic [NCH-1:0]   grant;
    logic [SEL_W-1:0] gidx;
    logic             any;
    logic             load_en;
    logic             xfer;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_split
        assign words[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    rr_arb8 u_arb (
        .req   (in_valid),
        .ptr   (ptr_reg),
        .grant (grant),
        .gidx  (gidx),
        .any   (any)
    );

    // The register can take a new word when empty or when it is being drained.
    assign load_en  = (state_reg == EMPTY) || out_ready;
    // rst_n gates the strobes so nothing is accepted while reset is held.
    assign in_ready = (rst_n && load_en) ? grant : '0;
    assign xfer     = rst_n && load_en && any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            ptr_reg   <= '0;
            data_reg  <= '0;
            sel_reg   <= '0;
        end else if (xfer) begin
            state_reg <= FULL;
            data_reg  <= words[gidx];
            sel_reg   <= gidx;
            ptr_reg   <= next_ptr(gidx);
        end else if (state_reg == FULL && out_ready) begin
            state_reg <= EMPTY;
        end
    end

    assign out_valid = (state_reg == FULL);
    assign out_data  = data_reg;
    assign out_sel   = sel_reg;

endmodule

// File: doc/mux8_arb.md
MUX8_ARB -- requirements
Module: mux8_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data word width per channel.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  8  per-channel word-present flag; bit k = channel k.
REQ-005 SHALL have port in_data  input  8*WIDTH  channel words packed; channel k at bits [k*WIDTH +: WIDTH].
REQ-006 SHALL have port in_ready  output  8  per-channel accept strobe; at most one bit set per cycle.
REQ-007 SHALL have port out_valid  output  1  output register holds a word.
REQ-008 SHALL have port out_data  output  WIDTH  held word.
REQ-009 SHALL have port out_sel  output  3  source channel index of held word, same encoding as demux8 sel.
REQ-010 SHALL have port out_ready  input  1  downstream accepts held word this cycle.

Function
REQ-011 SHALL merge 8 valid/ready channels into one registered valid/ready stream, tagging each word with its channel index.
REQ-012 SHALL transfer on a channel when in_valid[k] & in_ready[k] at a rising edge; output transfer when out_valid & out_ready.
REQ-013 SHALL operate a 2-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 SHALL define load_en = EMPTY | (FULL & out_ready).
REQ-015 SHALL assert in_ready[k] combinationally only when load_en and channel k holds the round-robin grant; in_ready SHALL never depend on in_valid of the same channel alone.
REQ-016 SHALL grant the first channel with in_valid set, searching upward from pointer ptr (3 bits) and wrapping 7 -> 0.
REQ-017 SHALL, on a channel transfer from channel g, load out_data = channel g word, out_sel = g, and set ptr = (g+1) mod 8 (7 -> 0).
REQ-018 SHALL leave ptr unchanged in cycles with no channel transfer.
REQ-019 SHALL present an accepted word on out_valid/out_data/out_sel the cycle after acceptance (latency 1).
REQ-020 SHALL hold out_data and out_sel stable while out_valid & !out_ready.
REQ-021 EMPTY -> FULL when a channel transfer occurs; FULL -> EMPTY when out_ready and no channel transfer; FULL -> FULL when out_ready and a simultaneous channel transfer (full throughput, one word per cycle).
REQ-022 SHALL not accept any channel word while FULL & !out_ready (all in_ready low).
REQ-023 SHALL, with all in_valid low, assert no in_ready and leave out_data/out_sel unchanged.
REQ-024 SHALL guarantee each continuously-valid channel is granted within 8 consecutive load cycles.

Reset
REQ-025 SHALL, on rst_n low, immediately force out_valid=0, out_data=0, out_sel=0, ptr=0, state EMPTY, regardless of clk.
REQ-026 SHALL drive in_ready all-zero while rst_n low.
REQ-027 SHALL discard a held word on reset mid-operation; no word is emitted after rst_n rises until a new channel transfer.
REQ-028 SHALL resume arbitration on the first rising edge after rst_n deasserts, starting from channel 0.

Structure
REQ-029 SHALL place NCH=8, SEL_W=3 and default WIDTH=16 in the shared package used with demux8.
REQ-030 SHALL implement grant selection in one combinational sub-module rr_arb8 (inputs req[7:0], ptr[2:0]; outputs grant[7:0] one-hot, gidx[2:0], any).
REQ-031 SHALL keep FSM, ptr, output register and data mux in mux8_arb; no other sub-modules.

Verification
REQ-032 Reset then in_valid=8'h04, in_data ch2=16'hBEEF, out_ready=1 -> in_ready=8'h04 same cycle; next cycle out_valid=1, out_data=16'hBEEF, out_sel=2; ptr=3.
REQ-033 in_valid=8'hFF held, out_ready=1 for 10 cycles -> out_sel sequence 0,1,2,3,4,5,6,7,0,1, one word per cycle.
REQ-034 ptr=6, in_valid=8'h21 -> grant ch0 after wrap (7 -> 0) not ch5; out_sel=0, then ptr=1, next grant ch5.
REQ-035 FULL with out_ready=0 for 5 cycles, in_valid=8'hFF -> in_ready=0, out_data/out_sel unchanged; out_ready=1 -> drain and reload in same cycle.
REQ-036 rst_n pulsed low between clock edges while FULL -> out_valid=0 immediately, out_sel=0; after release, in_valid=8'h80 -> out_sel=7 one cycle later.
